// File: rtl/asg_sweep_ctrl.sv
// Sweep scheduler for one ASG channel: ramps the channel pointer step from a
// start to a stop value with a programmable dwell, in single, sawtooth or triangle mode.
module asg_sweep_ctrl #(
  parameter int unsigned RSZ = 14,
  parameter int unsigned DW  = 32
) (
  input  logic              dac_clk_i,
  input  logic              dac_rstn_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic [RSZ+15:0]   cfg_start_i,
  input  logic [RSZ+15:0]   cfg_stop_i,
  input  logic [RSZ+15:0]   cfg_incr_i,
  input  logic [DW-1:0]     cfg_dwell_i,
  input  logic [1:0]        cfg_mode_i,
  output logic [RSZ+15:0]   step_o,
  output logic              step_upd_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [15:0]       sweep_cnt_o
);

  localparam int unsigned SW = RSZ + 16;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DWELL, S_ENDPT} state_t;

  state_t          state;
  logic [SW-1:0]   start_q, stop_q, incr_q, tgt_q;
  logic [DW-1:0]   dwell_q, cnt_q;
  logic [1:0]      mode_q;
  logic            up_q;
  logic            leg_q;

  logic            cfg_up_c;
  logic [SW-1:0]   cfg_span_c;
  logic [DW-1:0]   cfg_dwell_c;
  logic [SW-1:0]   tri_tgt_c;
  logic [SW-1:0]   ramp_next_c;
  logic [SW-1:0]   tri_next_c;

  // One step toward tgt, clamped on overshoot, carry or borrow.
  function automatic logic [SW-1:0] next_step(input logic up, input logic [SW-1:0] cur,
                                               input logic [SW-1:0] inc, input logic [SW-1:0] tgt);
    logic [SW:0] nxt;
    if (up) begin
      nxt = {1'b0, cur} + {1'b0, inc};
      next_step = (nxt[SW] || (nxt[SW-1:0] >= tgt)) ? tgt : nxt[SW-1:0];
    end else begin
      nxt = {1'b0, cur} - {1'b0, inc};
      next_step = (nxt[SW] || (nxt[SW-1:0] <= tgt)) ? tgt : nxt[SW-1:0];
    end
  endfunction

  assign cfg_up_c    = (cfg_stop_i >= cfg_start_i);
  assign cfg_span_c  = cfg_up_c ? (cfg_stop_i - cfg_start_i) : (cfg_start_i - cfg_stop_i);
  assign cfg_dwell_c = (cfg_dwell_i == '0) ? DW'(1) : cfg_dwell_i;
  // leg_q=0 means heading to the programmed stop, so the next target is the start
  assign tri_tgt_c   = leg_q ? stop_q : start_q;
  assign ramp_next_c = next_step(up_q, step_o, incr_q, tgt_q);
  assign tri_next_c  = next_step(!up_q, step_o, incr_q, tri_tgt_c);

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      state       <= S_IDLE;
      step_o      <= '0;
      step_upd_o  <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      sweep_cnt_o <= '0;
      start_q     <= '0;
      stop_q      <= '0;
      incr_q      <= '0;
      tgt_q       <= '0;
      dwell_q     <= '0;
      cnt_q       <= '0;
      mode_q      <= '0;
      up_q        <= 1'b0;
      leg_q       <= 1'b0;
    end else begin
      step_upd_o <= 1'b0;
      done_o     <= 1'b0;
      if (stop_i && (state != S_IDLE)) begin
        state  <= S_IDLE;
        busy_o <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_i && !stop_i) begin
              start_q <= cfg_start_i;
              stop_q  <= cfg_stop_i;
              tgt_q   <= cfg_stop_i;
              up_q    <= cfg_up_c;
              leg_q   <= 1'b0;
              incr_q  <= (cfg_incr_i == '0) ? cfg_span_c : cfg_incr_i;
              dwell_q <= cfg_dwell_c;
              mode_q  <= cfg_mode_i;
              state   <= S_LOAD;
            end
          end
          S_LOAD: begin
            step_o      <= start_q;
            step_upd_o  <= 1'b1;
            busy_o      <= 1'b1;
            cnt_q       <= dwell_q;
            sweep_cnt_o <= '0;
            state       <= S_DWELL;
          end
          S_DWELL: begin
            if (cnt_q == DW'(1)) begin
              if (step_o == tgt_q) begin
                state <= S_ENDPT;
              end else begin
                step_o     <= ramp_next_c;
                step_upd_o <= 1'b1;
                cnt_q      <= dwell_q;
              end
            end else begin
              cnt_q <= cnt_q - DW'(1);
            end
          end
          S_ENDPT: begin
            if (sweep_cnt_o != 16'hFFFF) sweep_cnt_o <= sweep_cnt_o + 16'd1;
            case (mode_q)
              2'd1: begin
                step_o     <= start_q;
                step_upd_o <= 1'b1;
                cnt_q      <= dwell_q;
                state      <= S_DWELL;
              end
              2'd2: begin
                tgt_q      <= tri_tgt_c;
                up_q       <= !up_q;
                leg_q      <= !leg_q;
                step_o     <= tri_next_c;
                step_upd_o <= 1'b1;
                cnt_q      <= dwell_q;
                state      <= S_DWELL;
              end
              default: begin
                done_o <= 1'b1;
                busy_o <= 1'b0;
                state  <= S_IDLE;
              end
            endcase
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/asg_sweep_ctrl.md
Name: asg_sweep_ctrl

Overview:
Sweep scheduler for one ASG channel. It drives the channel's pointer-step (frequency) setting through a programmed ramp from a start step to a stop step, holding each value for a programmed dwell time. It supports single, repeating sawtooth and triangle sweeps. It sits between the ASG register bank and the channel's set_step input, in the DAC clock domain.

Parameters:
RSZ, 14, buffer address width; step words are RSZ+16 bits wide (16 fractional bits)
DW, 32, dwell counter width

Ports:
dac_clk_i  in  1  DAC clock; the only clock
dac_rstn_i  in  1  reset, asynchronous, active-low
start_i  in  1  one-cycle start pulse; ignored while busy_o=1
stop_i  in  1  one-cycle abort pulse
cfg_start_i  in  RSZ+16  first step value
cfg_stop_i  in  RSZ+16  final step value
cfg_incr_i  in  RSZ+16  step increment magnitude
cfg_dwell_i  in  DW  clock cycles each step value is held; 0 is treated as 1
cfg_mode_i  in  2  0=single, 1=sawtooth repeat, 2=triangle repeat, 3=single
step_o  out  RSZ+16  step value to the ASG channel set_step input
step_upd_o  out  1  one-cycle pulse when step_o takes a new value
busy_o  out  1  sweep in progress
done_o  out  1  one-cycle pulse when a single sweep completes
sweep_cnt_o  out  16  completed endpoint count, saturating

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE; step_o=0, step_upd_o=0, busy_o=0, done_o=0, sweep_cnt_o=0; internal regs=0.
- Config is latched on the accepted start_i. Config changes during a sweep have no effect.
- Direction is latched at start: up if cfg_stop_i >= cfg_start_i (unsigned), else down.
- Target register tgt is loaded with cfg_stop_i. A latched incr of 0 is replaced by the full span |stop-start|, which gives a one-step jump.
- States:
  - IDLE
    - start_i=1 and stop_i=0 -> LOAD.
    - step_o holds its last value.
  - LOAD (1 cycle)
    - step_o<=cfg_start_i, step_upd_o=1, busy_o=1.
    - Dwell counter<=max(cfg_dwell_i,1).
    - sweep_cnt_o<=0.
    - Next state: DWELL.
  - DWELL
    - Counter decrements each cycle.
    - On the cycle the counter equals 1, evaluate the next step:
      - If step_o==tgt -> ENDPT.
      - Else next=step_o±incr, computed in RSZ+17 bits.
        - Up: if next>=tgt or a carry occurs, step_o<=tgt; else step_o<=next.
        - Down: if next<=tgt or a borrow occurs, step_o<=tgt; else step_o<=next.
        - step_upd_o=1 and the counter reloads.
  - ENDPT (1 cycle)
    - sweep_cnt_o increments, saturating at 16'hFFFF.
    - Single mode: done_o=1, busy_o<=0, step_o holds tgt -> IDLE.
    - Sawtooth: step_o<=latched start, step_upd_o=1, counter reloads -> DWELL.
    - Triangle: swap tgt between latched stop and latched start, invert direction. The endpoint value is not re-emitted. The next step is computed from step_o, with the same clamping rules, then step_upd_o=1 -> DWELL.
- Timing:
  - start_i at edge N -> step_o=start, step_upd_o=1, busy_o=1 visible after edge N+1.
  - Each value is held exactly D=max(dwell,1) cycles. Exception: the endpoint value is held D+1 cycles because of the ENDPT cycle.
- stop_i in any non-IDLE state -> IDLE next cycle:
  - busy_o=0, step_o holds, no done_o, no step_upd_o.
  - stop_i has priority over start_i and over any simultaneous endpoint or step.
- start_i while busy_o=1 is ignored. start_i and stop_i in the same cycle in IDLE: stop wins and no sweep starts.
- cfg_start_i==cfg_stop_i: start is emitted, held D cycles, then ENDPT.
- step_upd_o and done_o are never asserted for more than one cycle. done_o and step_upd_o are never asserted in the same cycle.
- Reset asserted mid-sweep: all outputs go to their reset values immediately.

Test Plan:
- Single up: start=0x1000, stop=0x4000, incr=0x1000, dwell=3, mode 0 -> step_o 0x1000,0x2000,0x3000,0x4000. step_upd_o every 3 cycles. done_o pulses 4 cycles after the last update. sweep_cnt_o=1, busy_o=0.
- Clamp/down: start=0x5000, stop=0x1800, incr=0x1000, dwell=1 -> 0x5000,0x4000,0x3000,0x2000,0x1800, then done_o. No underflow.
- Triangle: start=0, stop=0x300, incr=0x100, dwell=2, mode 2 -> 0,100,200,300,200,100,0,100... sweep_cnt_o increments at each endpoint. busy_o stays 1.
- Sawtooth with abort: mode 1, same ramp. stop_i asserted mid-dwell at 0x200 -> busy_o=0 next cycle, step_o stays 0x200, no done_o. A subsequent start_i restarts from 0 with sweep_cnt_o=0.
- Edge configs: dwell=0 and incr=0, start=0x10, stop=0x90 -> 0x10 held 1 cycle, 0x90 emitted next, then done_o. start_i+stop_i simultaneous in IDLE -> no activity.
- Async reset asserted mid-DWELL without a clock edge -> step_o=0, busy_o=0, sweep_cnt_o=0 immediately. Pulses on start_i while busy have no effect.
